// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: rename/execute interface records,
// entry layout and the branch-tracking state encoding.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int PREG_W    = 7;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] idx;
    } rd_t;

    typedef struct packed {
        logic valid;
        rd_t  rd;
        logic is_branch;
    } rinstr_t;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] idx;
        logic              ready;
    } p_reg_t;

    typedef struct packed {
        logic valid;
        logic hit;
    } br_result_t;

    typedef struct packed {
        logic valid;
        logic done;
        rd_t  rd;
        logic is_branch;
    } rob_entry_t;

    typedef enum logic {
        BR_IDLE    = 1'b0,
        BR_PENDING = 1'b1
    } br_state_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/execute-facing bundle of the reorder buffer; master drives
// instructions, writebacks and branch results, slave is the buffer itself.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W = 4
);
    rinstr_t           rinstr_i;
    br_result_t        br_result_i;
    logic              wb_valid_i;
    logic [TAG_W-1:0]  wb_tag_i;
    logic [TAG_W-1:0]  alloc_tag_o;
    logic              rob_full_o;
    logic              rob_empty_o;
    p_reg_t            p_commit_o;

    modport master (
        output rinstr_i, br_result_i, wb_valid_i, wb_tag_i,
        input  alloc_tag_o, rob_full_o, rob_empty_o, p_commit_o
    );

    modport slave (
        input  rinstr_i, br_result_i, wb_valid_i, wb_tag_i,
        output alloc_tag_o, rob_full_o, rob_empty_o, p_commit_o
    );
endinterface

// File: rtl/rob_ptr.sv
// Head/tail/occupancy bookkeeping for the reorder buffer, including the
// tail reload and occupancy recompute on a mispredict flush.
module rob_ptr #(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc,
    input  logic             commit,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tail,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic [TAG_W:0]   count
);

    // Entries dropped by a flush; never DEPTH, since the branch itself stays.
    logic [TAG_W-1:0] flush_span;
    assign flush_span = tail - flush_tail;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head + TAG_W'(commit);
            if (flush) begin
                tail  <= flush_tail;
                count <= count - (TAG_W+1)'(commit) - {1'b0, flush_span};
            end else begin
                tail  <= tail + TAG_W'(alloc);
                count <= count + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags to renamed instructions, records
// writebacks, commits the head in program order and squashes on mispredict.
//
//   state      | meaning
//   BR_IDLE    | no unresolved branch in flight
//   BR_PENDING | one branch allocated, br_tail marks the first younger slot
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    reorder_buffer_if.slave bus
);

    rob_entry_t       entries [DEPTH];
    logic [TAG_W-1:0] head, tail, br_tail;
    logic [TAG_W:0]   count;
    logic [TAG_W-1:0] flush_span;
    logic [DEPTH-1:0] kill;
    br_state_t        state, state_nxt;
    p_reg_t           p_commit;
    logic             full, resolve, flush_en, alloc_en, commit_en;

    assign full      = count == (TAG_W+1)'(DEPTH);
    assign resolve   = bus.br_result_i.valid && (state == BR_PENDING);
    assign flush_en  = resolve && !bus.br_result_i.hit;
    assign alloc_en  = bus.rinstr_i.valid && !full && !flush_en;
    assign commit_en = entries[head].valid && entries[head].done;

    rob_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ptr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .alloc      (alloc_en),
        .commit     (commit_en),
        .flush      (flush_en),
        .flush_tail (br_tail),
        .head       (head),
        .tail       (tail),
        .count      (count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            BR_IDLE:    if (alloc_en && bus.rinstr_i.is_branch) state_nxt = BR_PENDING;
            BR_PENDING: begin
                if (alloc_en && bus.rinstr_i.is_branch) state_nxt = BR_PENDING;
                else if (bus.br_result_i.valid)         state_nxt = BR_IDLE;
            end
            default:    state_nxt = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= BR_IDLE;
            br_tail <= '0;
        end else begin
            state <= state_nxt;
            if (alloc_en && bus.rinstr_i.is_branch) br_tail <= tail + 1'b1;
        end
    end

    // Wrong-path window is [br_tail, tail), measured as an offset from br_tail.
    assign flush_span = tail - br_tail;
    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++)
            kill[i] = flush_en && ((TAG_W'(i) - br_tail) < flush_span);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) begin
                    entries[i].valid <= 1'b0;
                end else begin
                    if (commit_en && TAG_W'(i) == head) entries[i].valid <= 1'b0;
                    if (bus.wb_valid_i && TAG_W'(i) == bus.wb_tag_i && entries[i].valid)
                        entries[i].done <= 1'b1;
                end
                if (alloc_en && TAG_W'(i) == tail)
                    entries[i] <= '{valid: 1'b1, done: 1'b0, rd: bus.rinstr_i.rd,
                                    is_branch: bus.rinstr_i.is_branch};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          p_commit <= '0;
        else if (commit_en) p_commit <= '{valid: entries[head].rd.valid,
                                          idx: entries[head].rd.idx, ready: 1'b1};
        else                p_commit <= '0;
    end

    assign bus.alloc_tag_o = tail;
    assign bus.rob_full_o  = full;
    assign bus.rob_empty_o = count == '0;
    assign bus.p_commit_o  = p_commit;

    // Only one branch may be unresolved; a second one is legal only as the
    // pending branch resolves correctly in the same cycle.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(state == BR_PENDING && alloc_en && bus.rinstr_i.is_branch && !bus.br_result_i.valid));

    assert property (@(posedge clk_i) disable iff (rst_i)
        (state == BR_PENDING && head == br_tail - 1'b1 && entries[head].valid)
            |-> entries[head].is_branch);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: table of per-cycle vectors plus
// hand-written fill/drain and asynchronous-reset wrap sequences.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.TAG_W(TAG_W)) bus ();
    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic             pre_rst;
        rinstr_t          ri;
        logic             wb_v;
        logic [TAG_W-1:0] wb_t;
        br_result_t       br;
        logic [TAG_W-1:0] tag;
        logic             full;
        logic             empty;
        p_reg_t           pc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam rinstr_t    RI_IDLE  = '0;
    localparam br_result_t BR_NONE  = '0;
    localparam br_result_t BR_MISS  = '{valid: 1'b1, hit: 1'b0};
    localparam br_result_t BR_HIT   = '{valid: 1'b1, hit: 1'b1};
    localparam p_reg_t     PC_NONE  = '0;
    localparam p_reg_t     PC_NORD  = '{valid: 1'b0, idx: '0, ready: 1'b1};

    function automatic rinstr_t ri(input int idx);
        return '{valid: 1'b1, rd: '{valid: 1'b1, idx: PREG_W'(idx)}, is_branch: 1'b0};
    endfunction

    function automatic rinstr_t ri_nord();
        return '{valid: 1'b1, rd: '0, is_branch: 1'b0};
    endfunction

    function automatic rinstr_t ri_br();
        return '{valid: 1'b1, rd: '0, is_branch: 1'b1};
    endfunction

    function automatic p_reg_t pcv(input int idx);
        return '{valid: 1'b1, idx: PREG_W'(idx), ready: 1'b1};
    endfunction

    function automatic void add(input logic pre, input rinstr_t r, input logic wv,
                                input int wt, input br_result_t b, input int tag,
                                input logic f, input logic e, input p_reg_t pc);
        vec_t v;
        v.pre_rst = pre; v.ri = r; v.wb_v = wv; v.wb_t = TAG_W'(wt); v.br = b;
        v.tag = TAG_W'(tag); v.full = f; v.empty = e; v.pc = pc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input rinstr_t r, input logic wv, input int wt, input br_result_t b);
        bus.rinstr_i    = r;
        bus.wb_valid_i  = wv;
        bus.wb_tag_i    = TAG_W'(wt);
        bus.br_result_i = b;
    endtask

    task automatic step(input rinstr_t r, input logic wv, input int wt, input br_result_t b);
        drive(r, wv, wt, b);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(RI_IDLE, 1'b0, 0, BR_NONE);
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // in-order commit, including an entry without a destination
        add(0, ri(32),    0, 0, BR_NONE, 1, 0, 0, PC_NONE);
        add(0, ri(33),    0, 0, BR_NONE, 2, 0, 0, PC_NONE);
        add(0, ri_nord(), 0, 0, BR_NONE, 3, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 0, BR_NONE, 3, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 1, BR_NONE, 3, 0, 0, pcv(32));
        add(0, RI_IDLE,   1, 2, BR_NONE, 3, 0, 0, pcv(33));
        add(0, RI_IDLE,   0, 0, BR_NONE, 3, 0, 1, PC_NORD);
        add(0, RI_IDLE,   0, 0, BR_NONE, 3, 0, 1, PC_NONE);
        // out-of-order writeback, commit held until the head completes
        add(0, ri(50),    0, 0, BR_NONE, 4, 0, 0, PC_NONE);
        add(0, ri(51),    0, 0, BR_NONE, 5, 0, 0, PC_NONE);
        add(0, ri(52),    0, 0, BR_NONE, 6, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 5, BR_NONE, 6, 0, 0, PC_NONE);
        add(0, RI_IDLE,   0, 0, BR_NONE, 6, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 3, BR_NONE, 6, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 4, BR_NONE, 6, 0, 0, pcv(50));
        add(0, RI_IDLE,   0, 0, BR_NONE, 6, 0, 0, pcv(51));
        add(0, RI_IDLE,   0, 0, BR_NONE, 6, 0, 1, pcv(52));
        add(0, RI_IDLE,   0, 0, BR_NONE, 6, 0, 1, PC_NONE);
        // mispredict: flush with same-cycle allocate and same-tag writeback
        add(1, ri(30),    0, 0, BR_NONE, 1, 0, 0, PC_NONE);
        add(0, ri_br(),   0, 0, BR_NONE, 2, 0, 0, PC_NONE);
        add(0, ri(40),    0, 0, BR_NONE, 3, 0, 0, PC_NONE);
        add(0, ri(41),    0, 0, BR_NONE, 4, 0, 0, PC_NONE);
        add(0, ri(77),    1, 3, BR_MISS, 2, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 3, BR_NONE, 2, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 0, BR_NONE, 2, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 1, BR_NONE, 2, 0, 0, pcv(30));
        add(0, RI_IDLE,   1, 2, BR_NONE, 2, 0, 1, PC_NORD);
        add(0, RI_IDLE,   0, 0, BR_NONE, 2, 0, 1, PC_NONE);
        add(0, ri(60),    0, 0, BR_NONE, 3, 0, 0, PC_NONE);
        add(0, RI_IDLE,   0, 0, BR_NONE, 3, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 2, BR_NONE, 3, 0, 0, PC_NONE);
        add(0, RI_IDLE,   0, 0, BR_NONE, 3, 0, 1, pcv(60));
        add(0, RI_IDLE,   0, 0, BR_MISS, 3, 0, 1, PC_NONE);
        // correct prediction: everything retained, same-cycle allocate kept
        add(1, ri(30),    0, 0, BR_NONE, 1, 0, 0, PC_NONE);
        add(0, ri_br(),   0, 0, BR_NONE, 2, 0, 0, PC_NONE);
        add(0, ri(40),    0, 0, BR_NONE, 3, 0, 0, PC_NONE);
        add(0, ri(41),    0, 0, BR_NONE, 4, 0, 0, PC_NONE);
        add(0, ri(42),    0, 0, BR_HIT,  5, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 0, BR_NONE, 5, 0, 0, PC_NONE);
        add(0, RI_IDLE,   1, 1, BR_NONE, 5, 0, 0, pcv(30));
        add(0, RI_IDLE,   1, 2, BR_NONE, 5, 0, 0, PC_NORD);
        add(0, RI_IDLE,   1, 3, BR_NONE, 5, 0, 0, pcv(40));
        add(0, RI_IDLE,   1, 4, BR_NONE, 5, 0, 0, pcv(41));
        add(0, RI_IDLE,   0, 0, BR_NONE, 5, 0, 1, pcv(42));

        drive(RI_IDLE, 1'b0, 0, BR_NONE);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset tag",   32'(bus.alloc_tag_o), 32'd0);
        chk("reset full",  32'(bus.rob_full_o),  32'd0);
        chk("reset empty", 32'(bus.rob_empty_o), 32'd1);
        chk("reset pc",    32'(bus.p_commit_o),  32'(PC_NONE));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre_rst) do_reset();
            step(vecs[i].ri, vecs[i].wb_v, int'(vecs[i].wb_t), vecs[i].br);
            chk($sformatf("row%0d tag", i),   32'(bus.alloc_tag_o), 32'(vecs[i].tag));
            chk($sformatf("row%0d full", i),  32'(bus.rob_full_o),  32'(vecs[i].full));
            chk($sformatf("row%0d empty", i), 32'(bus.rob_empty_o), 32'(vecs[i].empty));
            chk($sformatf("row%0d pc", i),    32'(bus.p_commit_o),  32'(vecs[i].pc));
        end

        // fill to DEPTH, overflow attempt, then drain with an alloc at full
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(ri(64 + i), 1'b0, 0, BR_NONE);
            chk($sformatf("fill%0d full", i), 32'(bus.rob_full_o), 32'(i == DEPTH - 1));
            chk($sformatf("fill%0d tag", i),  32'(bus.alloc_tag_o), 32'((i + 1) % DEPTH));
        end
        step(ri(99), 1'b0, 0, BR_NONE);
        chk("overflow full", 32'(bus.rob_full_o),  32'd1);
        chk("overflow tag",  32'(bus.alloc_tag_o), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step((i == 1) ? ri(98) : RI_IDLE, 1'b1, i, BR_NONE);
            chk($sformatf("drain%0d pc", i), 32'(bus.p_commit_o),
                (i == 0) ? 32'(PC_NONE) : 32'(pcv(64 + i - 1)));
            if (i == 1) begin
                chk("alloc at full full", 32'(bus.rob_full_o),  32'd0);
                chk("alloc at full tag",  32'(bus.alloc_tag_o), 32'd0);
            end
        end
        step(RI_IDLE, 1'b0, 0, BR_NONE);
        chk("drain last pc",    32'(bus.p_commit_o),  32'(pcv(64 + DEPTH - 1)));
        chk("drain last empty", 32'(bus.rob_empty_o), 32'd1);
        step(RI_IDLE, 1'b0, 0, BR_NONE);
        chk("drain idle pc",    32'(bus.p_commit_o),  32'(PC_NONE));

        // walk head to 14, wrap the tail, then reset asynchronously mid-flight
        do_reset();
        for (int i = 0; i < 14; i++) step(ri_nord(), 1'b0, 0, BR_NONE);
        for (int i = 0; i < 14; i++) step(RI_IDLE, 1'b1, i, BR_NONE);
        step(RI_IDLE, 1'b0, 0, BR_NONE);
        step(RI_IDLE, 1'b0, 0, BR_NONE);
        chk("wrap start tag",   32'(bus.alloc_tag_o), 32'd14);
        chk("wrap start empty", 32'(bus.rob_empty_o), 32'd1);
        step(ri(80), 1'b0, 0, BR_NONE);
        step(ri(81), 1'b0, 0, BR_NONE);
        chk("wrap tag rolls", 32'(bus.alloc_tag_o), 32'd0);
        step(ri(82), 1'b0, 0, BR_NONE);
        step(ri(83), 1'b0, 0, BR_NONE);
        chk("wrap tag 2", 32'(bus.alloc_tag_o), 32'd2);
        step(RI_IDLE, 1'b1, 14, BR_NONE);
        chk("wrap pc before", 32'(bus.p_commit_o), 32'(PC_NONE));
        step(RI_IDLE, 1'b1, 15, BR_NONE);
        chk("wrap pc 80", 32'(bus.p_commit_o), 32'(pcv(80)));
        drive(RI_IDLE, 1'b0, 0, BR_NONE);
        rst = 1'b1;
        #2;
        chk("async rst pc",    32'(bus.p_commit_o),  32'(PC_NONE));
        chk("async rst empty", 32'(bus.rob_empty_o), 32'd1);
        chk("async rst full",  32'(bus.rob_full_o),  32'd0);
        chk("async rst tag",   32'(bus.alloc_tag_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(RI_IDLE, (i == 0), 15, BR_NONE);
            chk($sformatf("post rst%0d pc", i),    32'(bus.p_commit_o),  32'(PC_NONE));
            chk($sformatf("post rst%0d empty", i), 32'(bus.rob_empty_o), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
